uart_reg_cmd_ctrl: RTL



---
 rtl/uart_reg_cmd_ctrl.sv | 169 ++++++++++++++++
 1 files changed

// File: rtl/uart_reg_cmd_ctrl.sv
// uart_reg_cmd_ctrl: byte-protocol command sequencer between uart_core and an
// 8-entry register bank. A command byte (bit7 write/read, bits[2:0] address,
// bits[6:3] zero) is followed by NB little-endian data bytes for writes. A write
// is answered with ACK_BYTE. A read streams NB bytes, LSB first. An illegal
// command byte is answered with NAK_BYTE.
//
// The TX_ACK / TX_NAK / TX_DATA states are the cycles in which the registered
// tx_valid pulse is visible on the port. Each byte is therefore launched on the
// edge that enters one of these states. This gives a NAK one cycle after the
// illegal byte and the first read byte two cycles after the command.
module uart_reg_cmd_ctrl #(
   parameter int          W_REG       = 32,
   parameter int          TIMEOUT_CYC = 100000,
   parameter logic [7:0]  ACK_BYTE    = 8'hA5,
   parameter logic [7:0]  NAK_BYTE    = 8'h5A
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [7:0]         rx_byte,
   input  logic               rx_valid,
   output logic [7:0]         tx_byte,
   output logic               tx_valid,
   input  logic               tx_done,
   output logic [8*W_REG-1:0] regs_flat,
   output logic [7:0]         reg_wr_stb,
   output logic [7:0]         err_cnt
);

   localparam int NB = W_REG / 8;
   localparam int TW = $clog2(TIMEOUT_CYC + 1);
   localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT_CYC - 1);
   localparam logic [3:0]    CNT_LAST   = 4'(NB - 1);

   typedef enum logic [2:0] {
      IDLE, RX_DATA, COMMIT, RD_LOAD, TX_ACK, TX_NAK, TX_DATA, TX_WAIT
   } state_t;

   state_t                  state;
   logic [7:0][W_REG-1:0]   regs;
   logic [2:0]              addr;
   logic [3:0]              byte_cnt;
   logic [TW-1:0]           timer;
   logic [W_REG-1:0]        asm_word;
   logic [W_REG-1:0]        asm_next;
   logic [W_REG-1:0]        shreg;
   logic [3:0]              tx_left;
   logic                    err_evt;
   logic                    cmd_illegal;

   assign regs_flat   = regs;
   assign cmd_illegal = (rx_byte[6:3] != 4'd0);

   // Incoming byte lands in the top byte so that, after NB bytes, the first
   // byte received has been shifted down to bits [7:0].
   always_comb begin
      asm_next = (asm_word >> 8) | (W_REG'(rx_byte) << (W_REG - 8));
   end

   // One error event per cycle at most. Illegal command, timeout and dropped
   // byte are mutually exclusive by state.
   always_comb begin
      err_evt = 1'b0;
      case (state)
         IDLE:    err_evt = rx_valid && cmd_illegal;
         RX_DATA: err_evt = !rx_valid && (timer == TIMER_LAST);
         default: err_evt = rx_valid;
      endcase
   end

   // Main sequencer. It owns the register bank, the tx pulse and the error counter.
   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         regs       <= '0;
         addr       <= '0;
         byte_cnt   <= '0;
         timer      <= '0;
         asm_word   <= '0;
         shreg      <= '0;
         tx_left    <= '0;
         tx_byte    <= '0;
         tx_valid   <= 1'b0;
         reg_wr_stb <= '0;
         err_cnt    <= '0;
      end else begin
         reg_wr_stb <= '0;
         tx_valid   <= 1'b0;
         if (err_evt && (err_cnt != 8'hFF))
            err_cnt <= err_cnt + 8'd1;

         case (state)
            IDLE: begin
               if (rx_valid) begin
                  addr <= rx_byte[2:0];
                  if (cmd_illegal) begin
                     tx_valid <= 1'b1;
                     tx_byte  <= NAK_BYTE;
                     tx_left  <= '0;
                     state    <= TX_NAK;
                  end else if (rx_byte[7]) begin
                     byte_cnt <= '0;
                     timer    <= '0;
                     state    <= RX_DATA;
                  end else begin
                     state    <= RD_LOAD;
                  end
               end
            end

            RX_DATA: begin
               if (rx_valid) begin
                  timer    <= '0;
                  asm_word <= asm_next;
                  byte_cnt <= byte_cnt + 4'd1;
                  if (byte_cnt == CNT_LAST) begin
                     regs[addr]       <= asm_next;
                     reg_wr_stb[addr] <= 1'b1;
                     state            <= COMMIT;
                  end
               end else if (timer == TIMER_LAST) begin
                  state <= IDLE;
               end else begin
                  timer <= timer + TW'(1);
               end
            end

            // reg_wr_stb is visible during this cycle. Launch the ACK next.
            COMMIT: begin
               tx_valid <= 1'b1;
               tx_byte  <= ACK_BYTE;
               tx_left  <= '0;
               state    <= TX_ACK;
            end

            // Snapshot the register. Nothing can write the bank until the
            // whole stream has gone out.
            RD_LOAD: begin
               tx_valid <= 1'b1;
               tx_byte  <= regs[addr][7:0];
               shreg    <= regs[addr] >> 8;
               tx_left  <= CNT_LAST;
               state    <= TX_DATA;
            end

            TX_ACK, TX_NAK, TX_DATA: begin
               state <= TX_WAIT;
            end

            // tx_done is honoured from the very first cycle in this state.
            TX_WAIT: begin
               if (tx_done) begin
                  if (tx_left != 4'd0) begin
                     tx_valid <= 1'b1;
                     tx_byte  <= shreg[7:0];
                     shreg    <= shreg >> 8;
                     tx_left  <= tx_left - 4'd1;
                     state    <= TX_DATA;
                  end else begin
                     state    <= IDLE;
                  end
               end
            end

            default: state <= IDLE;
         endcase
      end
   end

endmodule
